pcs_transmit: RTL and testbench

- 1000BASE-X PCS transmit ordered-set and code-group generator, the transmit-side counterpart of the PCS synchronization/receive path.
- Converts GMII-style TXD/TX_EN/TX_ER into a continuous stream of 10-bit code groups (PUDI) with correct running disparity and even/odd alignment.
- Emits /I1/ or /I2/ idles, /S/ start, data, /V/ error, and /T/R/ or /T/R/R/ end delimiters.
- Its PUDI output drives the PMA and feeds the synchronization block directly in loopback benches.

---
 rtl/pcs_transmit_pkg.sv | 141 ++++++++++++++
 rtl/pcs_transmit_encoder.sv | 40 ++++
 rtl/pcs_transmit.sv | 110 +++++++++++
 tb/tb_pcs_transmit.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pcs_transmit_pkg.sv
// 1000BASE-X PCS transmit shared definitions: code-group tables, ordered-set constants, FSM states.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package pcs_transmit_pkg;

    // Octet values of the special characters used by the transmit path
    localparam logic [7:0] OCT_K28_5 = 8'hBC;
    localparam logic [7:0] OCT_K27_7 = 8'hFB;
    localparam logic [7:0] OCT_K29_7 = 8'hFD;
    localparam logic [7:0] OCT_K23_7 = 8'hF7;
    localparam logic [7:0] OCT_K30_7 = 8'hFE;
    localparam logic [7:0] OCT_D16_2 = 8'h50;
    localparam logic [7:0] OCT_D5_6  = 8'hC5;

    // Ordered-set code groups, bit order {a,b,c,d,e,i,f,g,h,j}
    localparam logic [9:0] K28_5_NEG = 10'b0011111010;
    localparam logic [9:0] K28_5_POS = 10'b1100000101;
    localparam logic [9:0] K27_7_NEG = 10'b1101101000;
    localparam logic [9:0] K27_7_POS = 10'b0010010111;
    localparam logic [9:0] K29_7_NEG = 10'b1011101000;
    localparam logic [9:0] K29_7_POS = 10'b0100010111;
    localparam logic [9:0] K23_7_NEG = 10'b1110101000;
    localparam logic [9:0] K23_7_POS = 10'b0001010111;
    localparam logic [9:0] K30_7_NEG = 10'b0111101000;
    localparam logic [9:0] K30_7_POS = 10'b1000010111;
    localparam logic [9:0] D16_2_NEG = 10'b0110110101;
    localparam logic [9:0] D16_2_POS = 10'b1001000101;
    localparam logic [9:0] D5_6_NEG  = 10'b1010010110;
    localparam logic [9:0] D5_6_POS  = 10'b1010010110;

    // One-hot transmit FSM states
    localparam logic [5:0] ST_IDLE_K    = 6'b000001;
    localparam logic [5:0] ST_IDLE_D    = 6'b000010;
    localparam logic [5:0] ST_SOP       = 6'b000100;
    localparam logic [5:0] ST_TX_PACKET = 6'b001000;
    localparam logic [5:0] ST_EPD2      = 6'b010000;
    localparam logic [5:0] ST_EPD3      = 6'b100000;

    typedef enum logic [5:0] {
        IDLE_K    = ST_IDLE_K,
        IDLE_D    = ST_IDLE_D,
        SOP       = ST_SOP,
        TX_PACKET = ST_TX_PACKET,
        EPD2      = ST_EPD2,
        EPD3      = ST_EPD3
    } tx_state_t;

    typedef struct packed {
        logic       hit;
        logic [9:0] cg;
    } os_lookup_t;

    // 5b/6b sub-block: EDCBA -> abcdei, selected by the entering running disparity
    function automatic logic [5:0] enc_5b6b(input logic [4:0] x, input logic rd);
        logic [5:0] r;
        r = 6'b000000;
        case (x)
            5'd0:  r = rd ? 6'b011000 : 6'b100111;
            5'd1:  r = rd ? 6'b100010 : 6'b011101;
            5'd2:  r = rd ? 6'b010010 : 6'b101101;
            5'd3:  r = 6'b110001;
            5'd4:  r = rd ? 6'b001010 : 6'b110101;
            5'd5:  r = 6'b101001;
            5'd6:  r = 6'b011001;
            5'd7:  r = rd ? 6'b000111 : 6'b111000;
            5'd8:  r = rd ? 6'b000110 : 6'b111001;
            5'd9:  r = 6'b100101;
            5'd10: r = 6'b010101;
            5'd11: r = 6'b110100;
            5'd12: r = 6'b001101;
            5'd13: r = 6'b101100;
            5'd14: r = 6'b011100;
            5'd15: r = rd ? 6'b101000 : 6'b010111;
            5'd16: r = rd ? 6'b100100 : 6'b011011;
            5'd17: r = 6'b100011;
            5'd18: r = 6'b010011;
            5'd19: r = 6'b110010;
            5'd20: r = 6'b001011;
            5'd21: r = 6'b101010;
            5'd22: r = 6'b011010;
            5'd23: r = rd ? 6'b000101 : 6'b111010;
            5'd24: r = rd ? 6'b001100 : 6'b110011;
            5'd25: r = 6'b100110;
            5'd26: r = 6'b010110;
            5'd27: r = rd ? 6'b001001 : 6'b110110;
            5'd28: r = 6'b001110;
            5'd29: r = rd ? 6'b010001 : 6'b101110;
            5'd30: r = rd ? 6'b100001 : 6'b011110;
            default: r = rd ? 6'b010100 : 6'b101011;
        endcase
        return r;
    endfunction

    // 3b/4b sub-block: HGF -> fghj. rd is the disparity after the 6b sub-block.
    // D.x.7 switches to the alternate form where the primary one would make
    // a run of five identical bits across the sub-block boundary.
    function automatic logic [3:0] enc_3b4b(input logic [2:0] y, input logic [4:0] x, input logic rd);
        logic [3:0] r;
        logic       alt;
        alt = rd ? (x == 5'd11 || x == 5'd13 || x == 5'd14)
                 : (x == 5'd17 || x == 5'd18 || x == 5'd20);
        r = 4'b0000;
        case (y)
            3'd0:    r = rd ? 4'b0100 : 4'b1011;
            3'd1:    r = 4'b1001;
            3'd2:    r = 4'b0101;
            3'd3:    r = rd ? 4'b0011 : 4'b1100;
            3'd4:    r = rd ? 4'b0010 : 4'b1101;
            3'd5:    r = 4'b1010;
            3'd6:    r = 4'b0110;
            default: r = alt ? (rd ? 4'b1000 : 4'b0111) : (rd ? 4'b0001 : 4'b1110);
        endcase
        return r;
    endfunction

    // Ordered-set characters come straight from the literal constants.
    // Any control octet outside the PCS set collapses to the comma.
    function automatic os_lookup_t ordered_set_code(input logic [7:0] octet, input logic is_k,
                                                    input logic rd);
        os_lookup_t r;
        r.hit = 1'b1;
        r.cg  = rd ? K28_5_POS : K28_5_NEG;
        if (is_k) begin
            case (octet)
                OCT_K27_7: r.cg = rd ? K27_7_POS : K27_7_NEG;
                OCT_K29_7: r.cg = rd ? K29_7_POS : K29_7_NEG;
                OCT_K23_7: r.cg = rd ? K23_7_POS : K23_7_NEG;
                OCT_K30_7: r.cg = rd ? K30_7_POS : K30_7_NEG;
                default:   r.cg = rd ? K28_5_POS : K28_5_NEG;
            endcase
        end else begin
            case (octet)
                OCT_D16_2: r.cg = rd ? D16_2_POS : D16_2_NEG;
                OCT_D5_6:  r.cg = rd ? D5_6_POS  : D5_6_NEG;
                default:   r.hit = 1'b0;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/pcs_transmit_encoder.sv
// Combinational 8b/10b encoder for data octets and the PCS control characters.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: octet/is_k select the character, rd_in is the entering running
// disparity (1 = positive); code_group is {a..j} with a at bit 9, rd_out the
// disparity after it.
module encoder_8b10b
    import pcs_transmit_pkg::*;
(
    input  logic [7:0] octet,
    input  logic       is_k,
    input  logic       rd_in,
    output logic [9:0] code_group,
    output logic       rd_out
);

    logic [5:0] sb6;
    logic [3:0] sb4;
    logic       rd_mid;
    logic [2:0] ones6;
    logic [3:0] ones10;
    os_lookup_t os;

    always_comb begin
        sb6    = enc_5b6b(octet[4:0], rd_in);
        ones6  = 3'($countones(sb6));
        // An unbalanced 6b block sets the disparity seen by the 4b block
        rd_mid = (ones6 > 3'd3) ? 1'b1 : ((ones6 < 3'd3) ? 1'b0 : rd_in);
        sb4    = enc_3b4b(octet[7:5], octet[4:0], rd_mid);
        os     = ordered_set_code(octet, is_k, rd_in);

        code_group = (os.hit) ? os.cg : {sb6, sb4};

        // A legal code group carries 4, 5 or 6 ones, so its weight alone
        // gives the resulting running disparity.
        ones10 = 4'($countones(code_group));
        rd_out = (ones10 > 4'd5) ? 1'b1 : ((ones10 < 4'd5) ? 1'b0 : rd_in);
    end

endmodule

// File: rtl/pcs_transmit.sv
// 1000BASE-X PCS transmit: GMII TXD/TX_EN/TX_ER to a continuous 10-bit code-group stream.
// Latency: 1 cycle, every output registered; one code group loaded per clock.
// Backpressure: none, the stream never stalls; TX_EN is ignored outside IDLE_D/TX_PACKET.
// Ports: Clk, mr_main_reset (async, active high); TXD/TX_EN/TX_ER GMII inputs;
// PUDI code group {a..j} with a at bit 9; tx_even marks even positions;
// transmitting is high while /S/, data, /V/, /T/ or /R/ is on PUDI.
module pcs_transmit
    import pcs_transmit_pkg::*;
(
    input  logic       Clk,
    input  logic       mr_main_reset,
    input  logic [7:0] TXD,
    input  logic       TX_EN,
    input  logic       TX_ER,
    output logic [9:0] PUDI,
    output logic       tx_even,
    output logic       transmitting
);

    // state names the code group loaded on the next edge
    tx_state_t  state;
    tx_state_t  state_nxt;
    logic       rd;
    logic       i1_sel;
    logic       i1_sel_nxt;
    logic       xmit_nxt;
    logic [7:0] enc_octet;
    logic       enc_is_k;
    logic [9:0] enc_cg;
    logic       enc_rd;

    encoder_8b10b u_encoder (
        .octet      (enc_octet),
        .is_k       (enc_is_k),
        .rd_in      (rd),
        .code_group (enc_cg),
        .rd_out     (enc_rd)
    );

    always_comb begin
        state_nxt  = IDLE_K;
        i1_sel_nxt = i1_sel;
        xmit_nxt   = 1'b0;
        enc_octet  = OCT_K28_5;
        enc_is_k   = 1'b1;
        case (state)
            IDLE_K: begin
                // /I1/ after a positive-rd comma restores negative rd
                i1_sel_nxt = rd;
                state_nxt  = IDLE_D;
            end
            IDLE_D: begin
                enc_octet = i1_sel ? OCT_D5_6 : OCT_D16_2;
                enc_is_k  = 1'b0;
                state_nxt = TX_EN ? SOP : IDLE_K;
            end
            SOP: begin
                // the preamble octet on TXD this cycle is replaced by /S/
                enc_octet = OCT_K27_7;
                xmit_nxt  = 1'b1;
                state_nxt = TX_PACKET;
            end
            TX_PACKET: begin
                xmit_nxt = 1'b1;
                if (TX_EN) begin
                    enc_octet = TX_ER ? OCT_K30_7 : TXD;
                    enc_is_k  = TX_ER;
                    state_nxt = TX_PACKET;
                end else begin
                    enc_octet = OCT_K29_7;
                    state_nxt = EPD2;
                end
            end
            EPD2: begin
                enc_octet = OCT_K23_7;
                xmit_nxt  = 1'b1;
                // current PUDI odd means this /R/ is even: add a second /R/
                // so the next comma lands on an even position
                state_nxt = tx_even ? IDLE_K : EPD3;
            end
            EPD3: begin
                enc_octet = OCT_K23_7;
                xmit_nxt  = 1'b1;
                state_nxt = IDLE_K;
            end
            default: begin
                state_nxt = IDLE_K;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge mr_main_reset) begin
        if (mr_main_reset) begin
            state        <= IDLE_D;
            PUDI         <= K28_5_NEG;
            tx_even      <= 1'b1;
            rd           <= 1'b1;
            i1_sel       <= 1'b0;
            transmitting <= 1'b0;
        end else begin
            state        <= state_nxt;
            PUDI         <= enc_cg;
            tx_even      <= ~tx_even;
            rd           <= enc_rd;
            i1_sel       <= i1_sel_nxt;
            transmitting <= xmit_nxt;
        end
    end

endmodule

// File: tb/tb_pcs_transmit.sv
module tb_pcs_transmit;

    logic       Clk = 1'b0;
    logic       mr_main_reset = 1'b0;
    logic [7:0] TXD = 8'h00;
    logic       TX_EN = 1'b0;
    logic       TX_ER = 1'b0;
    logic [9:0] PUDI;
    logic       tx_even;
    logic       transmitting;

    pcs_transmit dut (
        .Clk           (Clk),
        .mr_main_reset (mr_main_reset),
        .TXD           (TXD),
        .TX_EN         (TX_EN),
        .TX_ER         (TX_ER),
        .PUDI          (PUDI),
        .tx_even       (tx_even),
        .transmitting  (transmitting)
    );

    always #5 Clk = ~Clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input int idx, input logic [9:0] got, input logic [9:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s #%0d: got %b expected %b", name, idx, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // 8b/10b from the RD- tables: at positive disparity an unbalanced sub-block
    // is complemented, as are the balanced-but-alternating D.7 / D.x.3 / all K.x.y.
    function automatic bit [10:0] m_encode(input bit k, input bit [7:0] oct, input bit rd_in);
        bit [5:0] t6 [32];
        bit [3:0] t4d [8];
        bit [3:0] t4k [8];
        bit [4:0] x;
        bit [2:0] y;
        bit [5:0] s6;
        bit [3:0] s4;
        bit       r;
        t6 = '{6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
               6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
               6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
               6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
        t4d = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
        t4k = '{4'b1011, 4'b0110, 4'b1010, 4'b1100, 4'b1101, 4'b0101, 4'b1001, 4'b0111};
        x = oct[4:0];
        y = oct[7:5];
        r = rd_in;
        s6 = (k && x == 5'd28) ? 6'b001111 : t6[x];
        if (r && ($countones(s6) != 3 || x == 5'd7)) s6 = ~s6;
        if ($countones(s6) > 3) r = 1'b1;
        else if ($countones(s6) < 3) r = 1'b0;
        if (k) s4 = t4k[y];
        else if (y == 3'd7 && ((!r && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
                               (r && (x == 5'd11 || x == 5'd13 || x == 5'd14)))) s4 = 4'b0111;
        else s4 = t4d[y];
        if (r && (k || $countones(s4) != 2 || y == 3'd3)) s4 = ~s4;
        if ($countones(s4) > 2) r = 1'b1;
        else if ($countones(s4) < 2) r = 1'b0;
        return {r, s6, s4};
    endfunction

    typedef struct {
        bit       k;
        bit [7:0] oct;
        bit       idle_d;   // second half of an idle pair, octet chosen when sent
        bit       xmit;
    } msym_t;

    function automatic msym_t mk(input bit k, input bit [7:0] oct, input bit idle_d, input bit xmit);
        msym_t s;
        s.k = k; s.oct = oct; s.idle_d = idle_d; s.xmit = xmit;
        return s;
    endfunction

    msym_t      mq[$];      // symbols already committed to the line
    bit         m_rd, m_i1, m_in_frame, m_start;
    int         m_pos;
    logic [9:0] m_pudi;
    bit         m_even, m_xmit;

    task automatic model_reset();
        mq.delete();
        mq.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0));
        m_rd = 1'b1; m_i1 = 1'b0; m_in_frame = 1'b0; m_start = 1'b0;
        m_pos = 0; m_pudi = 10'b0011111010; m_even = 1'b1; m_xmit = 1'b0;
    endtask

    task automatic model_step(input bit en, input bit er, input bit [7:0] d);
        msym_t     s;
        bit [10:0] e;
        m_pos++;
        if (mq.size() > 0) begin
            s = mq.pop_front();
            if (s.idle_d) begin
                s.oct = m_i1 ? 8'hC5 : 8'h50;
                if (en) m_start = 1'b1;
            end
        end else if (m_start) begin
            s = mk(1'b1, 8'hFB, 1'b0, 1'b1);
            m_start = 1'b0;
            m_in_frame = 1'b1;
        end else if (m_in_frame) begin
            if (!en) begin
                s = mk(1'b1, 8'hFD, 1'b0, 1'b1);
                m_in_frame = 1'b0;
                mq.push_back(mk(1'b1, 8'hF7, 1'b0, 1'b1));
                if (((m_pos + 1) % 2) == 0) mq.push_back(mk(1'b1, 8'hF7, 1'b0, 1'b1));
            end else if (er) begin
                s = mk(1'b1, 8'hFE, 1'b0, 1'b1);
            end else begin
                s = mk(1'b0, d, 1'b0, 1'b1);
            end
        end else begin
            s = mk(1'b1, 8'hBC, 1'b0, 1'b0);
            m_i1 = m_rd;
            mq.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0));
        end
        e = m_encode(s.k, s.oct, m_rd);
        m_rd   = e[10];
        m_pudi = e[9:0];
        m_even = (m_pos % 2) == 0;
        m_xmit = s.xmit;
    endtask

    task automatic tick_model(input bit en, input bit er, input bit [7:0] d, input string tag, input int idx);
        TX_EN = en; TX_ER = er; TXD = d;
        @(posedge Clk);
        model_step(en, er, d);
        #1;
        check({tag, "_pudi"}, idx, PUDI, m_pudi);
        check({tag, "_even"}, idx, {9'd0, tx_even}, {9'd0, m_even});
        check({tag, "_xmit"}, idx, {9'd0, transmitting}, {9'd0, m_xmit});
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit       en;
        bit       er;
        bit [7:0] txd;
        bit [9:0] pudi;
        bit       even;
        bit       xmit;
    } vec_t;

    vec_t tbl [30];

    initial begin
        // idle /I2/ after reset
        tbl[0]  = '{0, 0, 8'h00, 10'b1001000101, 0, 0};  // D16.2 RD+
        tbl[1]  = '{0, 0, 8'h00, 10'b0011111010, 1, 0};  // K28.5 RD-
        // frame: /S/ D0.0 /V/ D0.0 /T/ /R/  (/R/ odd -> single)
        tbl[2]  = '{1, 0, 8'hAA, 10'b1001000101, 0, 0};  // TX_EN seen in IDLE_D
        tbl[3]  = '{1, 0, 8'h55, 10'b1101101000, 1, 1};  // /S/, preamble dropped
        tbl[4]  = '{1, 0, 8'h00, 10'b1001110100, 0, 1};  // D0.0 RD-
        tbl[5]  = '{1, 1, 8'h00, 10'b0111101000, 1, 1};  // /V/ K30.7 RD-
        tbl[6]  = '{1, 0, 8'h00, 10'b1001110100, 0, 1};  // D0.0 RD-
        tbl[7]  = '{0, 0, 8'h00, 10'b1011101000, 1, 1};  // /T/ RD-
        tbl[8]  = '{0, 0, 8'h00, 10'b1110101000, 0, 1};  // /R/ RD-
        tbl[9]  = '{0, 0, 8'h00, 10'b0011111010, 1, 0};  // K28.5 even
        tbl[10] = '{0, 0, 8'h00, 10'b1001000101, 0, 0};
        // frame leaving rd positive, /T/R/R/, then /I1/
        tbl[11] = '{0, 0, 8'h00, 10'b0011111010, 1, 0};
        tbl[12] = '{1, 0, 8'h00, 10'b1001000101, 0, 0};
        tbl[13] = '{1, 0, 8'h00, 10'b1101101000, 1, 1};  // /S/
        tbl[14] = '{1, 0, 8'h03, 10'b1100011011, 0, 1};  // D3.0 RD- -> rd+
        tbl[15] = '{1, 0, 8'h00, 10'b0110001011, 1, 1};  // D0.0 RD+
        tbl[16] = '{0, 0, 8'h00, 10'b0100010111, 0, 1};  // /T/ RD+
        tbl[17] = '{0, 0, 8'h00, 10'b0001010111, 1, 1};  // /R/ RD+ even
        tbl[18] = '{0, 0, 8'h00, 10'b0001010111, 0, 1};  // second /R/
        tbl[19] = '{0, 0, 8'h00, 10'b1100000101, 1, 0};  // K28.5 RD+
        tbl[20] = '{0, 0, 8'h00, 10'b1010010110, 0, 0};  // D5.6 (/I1/)
        tbl[21] = '{0, 0, 8'h00, 10'b0011111010, 1, 0};
        // one-cycle TX_EN pulse, TX_EN during EPD3/IDLE_K, TX_ER alone
        tbl[22] = '{1, 0, 8'h00, 10'b1001000101, 0, 0};
        tbl[23] = '{0, 0, 8'h00, 10'b1101101000, 1, 1};  // /S/
        tbl[24] = '{0, 0, 8'h00, 10'b1011101000, 0, 1};  // /T/
        tbl[25] = '{0, 0, 8'h00, 10'b1110101000, 1, 1};  // /R/ even
        tbl[26] = '{1, 0, 8'h00, 10'b1110101000, 0, 1};  // /R/, TX_EN ignored
        tbl[27] = '{1, 0, 8'h00, 10'b0011111010, 1, 0};  // IDLE_K ignores TX_EN
        tbl[28] = '{0, 1, 8'h00, 10'b1001000101, 0, 0};  // TX_ER alone ignored
        tbl[29] = '{0, 0, 8'h00, 10'b0011111010, 1, 0};
    end

    initial begin
        #2;
        mr_main_reset = 1'b1;
        #1;
        check("reset_pudi", 0, PUDI, 10'b0011111010);
        check("reset_even", 0, {9'd0, tx_even}, 10'd1);
        check("reset_xmit", 0, {9'd0, transmitting}, 10'd0);
        @(posedge Clk);
        @(posedge Clk);
        #1;
        mr_main_reset = 1'b0;

        for (int i = 0; i < 30; i++) begin
            TX_EN = tbl[i].en; TX_ER = tbl[i].er; TXD = tbl[i].txd;
            @(posedge Clk);
            #1;
            check("tbl_pudi", i, PUDI, tbl[i].pudi);
            check("tbl_even", i, {9'd0, tx_even}, {9'd0, tbl[i].even});
            check("tbl_xmit", i, {9'd0, transmitting}, {9'd0, tbl[i].xmit});
        end

        // random frames against the model
        TX_EN = 1'b0;
        mr_main_reset = 1'b1;
        @(posedge Clk);
        #1;
        mr_main_reset = 1'b0;
        model_reset();
        for (int f = 0; f < 150; f++) begin
            int gap;
            int len;
            gap = $urandom_range(0, 5);
            len = $urandom_range(1, 16);
            for (int g = 0; g < gap; g++)
                tick_model(1'b0, 1'($urandom_range(0, 1)), 8'($urandom), "rnd", f);
            for (int b = 0; b < len; b++)
                tick_model(1'b1, ($urandom_range(0, 15) == 0), 8'($urandom), "rnd", f);
        end

        // reset pulsed mid-frame
        for (int i = 0; i < 4; i++) tick_model(1'b0, 1'b0, 8'h00, "pre", i);
        for (int i = 0; i < 5; i++) tick_model(1'b1, 1'b0, 8'($urandom), "pre", i);
        mr_main_reset = 1'b1;
        #1;
        check("midrst_pudi", 0, PUDI, 10'b0011111010);
        check("midrst_even", 0, {9'd0, tx_even}, 10'd1);
        check("midrst_xmit", 0, {9'd0, transmitting}, 10'd0);
        TX_EN = 1'b0;
        @(posedge Clk);
        #1;
        check("midrst_hold", 0, PUDI, 10'b0011111010);
        mr_main_reset = 1'b0;
        model_reset();
        for (int i = 0; i < 8; i++) tick_model(1'b0, 1'b0, 8'h00, "post", i);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
